imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 wb_clk_i  input  1  sole clock; all state updates on rising edge.
REQ-002 wb_rst_i  input  1  synchronous, active-high reset.
REQ-003 load_start  input  1  single-cycle pulse; begins a program load; honoured only in IDLE or READY.
REQ-004 load_len  input  10  word count of the program, sampled on the load_start cycle.
REQ-005 byte_valid  input  1  loader byte-stream valid.
REQ-006 byte_data  input  8  loader byte-stream data.
REQ-007 byte_ready  output  1  block accepts byte_data; a transfer occurs when byte_valid and byte_ready are both high on a rising edge.
REQ-008 run_en  input  1  software run request for the core.
REQ-009 insMemAddr  input  9  core fetch word address.
REQ-010 insMemDataIn  output  32  instruction word returned to the core, combinational from insMemAddr.
REQ-011 insMemEn  output  1  instruction memory valid; core executes NOP while low.
REQ-012 pc_control  output  1  core PC advance enable.
REQ-013 load_busy  output  1  high in LOAD and CHECK.
REQ-014 word_count  output  10  number of words written in the current or last load.
REQ-015 load_err  output  1  checksum failure flag; constant 0 without CHECKSUM_EN.

Function
REQ-016 The block SHALL hold 512 x 32-bit instruction storage with one write port (loader) and one asynchronous read port (core).
REQ-017 FSM states SHALL be IDLE, LOAD, CHECK and READY.
- IDLE->LOAD on load_start.
- LOAD->CHECK (CHECKSUM_EN) or ->READY when word_count reaches the effective length.
- CHECK->READY on a match, or ->IDLE with load_err set on a mismatch.
- READY->LOAD on load_start.
REQ-018 The effective length SHALL be min(load_len, 512).
- load_len = 0: the block leaves LOAD on the next cycle with word_count = 0.
REQ-019 byte_ready SHALL be high only in LOAD and CHECK.
REQ-020 Bytes SHALL be assembled little-endian.
- 1st byte -> bits 7:0, 4th byte -> bits 31:24.
- The word is written at address word_count on the edge that accepts the 4th byte.
- word_count increments on that same edge.
REQ-021 Byte acceptance SHALL be gap-tolerant: byte_valid low stalls assembly with no timeout.
REQ-022 On load_start from READY, word_count and the partial-byte counter SHALL clear, and insMemEn SHALL drop on the following cycle.
REQ-023 A load_start pulse arriving in LOAD or CHECK SHALL be ignored.
REQ-024 insMemDataIn SHALL equal the stored word when insMemAddr < word_count, and 32'h0000_0013 (NOP) otherwise.
REQ-025 insMemEn SHALL be high only in READY.
REQ-026 pc_control SHALL equal insMemEn AND run_en, so the core PC is frozen during load.
REQ-027 Latency from the accepting edge of the final payload byte to insMemEn high SHALL be 1 cycle without CHECKSUM_EN.

Reset
REQ-028 When wb_rst_i is high, the block SHALL go to IDLE on the next edge from any state, including mid-word and mid-load.
REQ-029 Reset values: word_count=0, byte counter=0, load_err=0, insMemEn=0, pc_control=0, byte_ready=0, load_busy=0.
REQ-030 Storage contents SHALL NOT be reset; they are masked by word_count=0, so every fetch returns NOP.

Configuration
REQ-031 CHECKSUM_EN defined:
- After the payload, LOAD->CHECK; the block accepts 4 more bytes as an expected checksum word.
- The expected checksum is compared with the XOR of all payload words.
- On a match, READY with load_err=0; on a mismatch, IDLE with load_err=1.
- load_err clears on the next load_start or on reset.
REQ-032 CHECKSUM_EN undefined: the CHECK state and the XOR logic SHALL be absent, and load_err SHALL be tied to 0.

Verification
REQ-033 Reset mid-load: load_len=4, send 6 bytes, assert wb_rst_i -> next cycle word_count=0, insMemEn=0, any insMemAddr returns 32'h13.
REQ-034 Basic load: load_len=2, bytes 13,05,10,00,93,05,20,00 with run_en=1 -> insMemAddr 0 = 32'h00100513, insMemAddr 1 = 32'h00200593, insMemAddr 2 = 32'h13, insMemEn and pc_control high 1 cycle after the last byte.
REQ-035 Stalled stream: byte_valid toggles every other cycle, load_len=1, bytes EF,BE,AD,DE -> word 0 = 32'hDEADBEEF, word_count=1.
REQ-036 Boundaries: load_len=600 -> exactly 512 words accepted and byte_ready low afterwards; load_len=0 -> READY with every fetch returning NOP.
REQ-037 CHECKSUM_EN: words 32'h1, 32'h2 followed by checksum 32'h3 -> READY, load_err=0; same payload with checksum 32'h4 -> IDLE, load_err=1, insMemEn=0.
REQ-038 Reload from READY: load_start with run_en=1 -> pc_control low the next cycle and word_count=0 until new words arrive.

Source files
------------

// File: rtl/imem_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module : imem_loader_if
// Brief  : Byte-stream loader and core instruction-fetch signal bundle.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface imem_loader_if;
  logic        load_start;
  logic [9:0]  load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        run_en;
  logic [8:0]  insMemAddr;
  logic [31:0] insMemDataIn;
  logic        insMemEn;
  logic        pc_control;
  logic        load_busy;
  logic [9:0]  word_count;
  logic        load_err;

  modport slave (
    input  load_start, load_len, byte_valid, byte_data, run_en, insMemAddr,
    output byte_ready, insMemDataIn, insMemEn, pc_control, load_busy,
           word_count, load_err
  );

  modport master (
    output load_start, load_len, byte_valid, byte_data, run_en, insMemAddr,
    input  byte_ready, insMemDataIn, insMemEn, pc_control, load_busy,
           word_count, load_err
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module : imem_loader
// Brief  : 512x32 instruction memory filled from a little-endian byte stream;
//          optional trailing XOR checksum word enabled by `define CHECKSUM_EN.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module imem_loader (
  input  wire logic    wb_clk_i,
  input  wire logic    wb_rst_i,
  imem_loader_if.slave bus
);

`ifdef CHECKSUM_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2,
    S_CHECK = 2'd3
  } state_t;
  localparam state_t c_PAYLOAD_DONE = S_CHECK;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;
  localparam state_t c_PAYLOAD_DONE = S_READY;
`endif

  localparam int          c_DEPTH   = 512;
  localparam logic [9:0]  c_MAX_LEN = 10'd512;
  localparam logic [31:0] c_NOP     = 32'h0000_0013;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_mem [0:c_DEPTH-1];
  logic [9:0]  r_word_count;
  logic [9:0]  r_eff_len;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_word_buf;

  logic        w_start;
  logic        w_byte_ready;
  logic        w_accept;
  logic        w_word_accept;
  logic        w_last_word;
  logic        w_ready;
  logic [9:0]  w_eff_len;
  logic [31:0] w_word;

  assign w_eff_len     = (bus.load_len > c_MAX_LEN) ? c_MAX_LEN : bus.load_len;
  assign w_start       = bus.load_start && ((r_state == S_IDLE) || (r_state == S_READY));
  assign w_accept      = bus.byte_valid && w_byte_ready;
  assign w_word_accept = w_accept && (r_byte_cnt == 2'd3);
  assign w_word        = {bus.byte_data, r_word_buf};
  assign w_last_word   = (r_word_count + 10'd1) == r_eff_len;
  assign w_ready       = (r_state == S_READY);

`ifdef CHECKSUM_EN
  logic [31:0] r_xor;
  logic        r_load_err;
  logic        w_sum_match;

  assign w_sum_match  = (w_word == r_xor);
  assign w_byte_ready = ((r_state == S_LOAD) && (r_word_count != r_eff_len)) ||
                        (r_state == S_CHECK);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_xor      <= 32'd0;
      r_load_err <= 1'b0;
    end else if (w_start) begin
      r_xor      <= 32'd0;
      r_load_err <= 1'b0;
    end else if (w_word_accept) begin
      if (r_state == S_LOAD)
        r_xor <= r_xor ^ w_word;
      else if ((r_state == S_CHECK) && !w_sum_match)
        r_load_err <= 1'b1;
    end
  end

  assign bus.load_err  = r_load_err;
  assign bus.load_busy = (r_state == S_LOAD) || (r_state == S_CHECK);
`else
  assign w_byte_ready  = (r_state == S_LOAD) && (r_word_count != r_eff_len);
  assign bus.load_err  = 1'b0;
  assign bus.load_busy = (r_state == S_LOAD);
`endif

  // Leave LOAD on the edge that completes the last word so the core sees
  // valid memory on the very next cycle; a zero length leaves immediately.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next_state = S_LOAD;
      S_LOAD:  if ((r_word_count == r_eff_len) || (w_word_accept && w_last_word))
                 w_next_state = c_PAYLOAD_DONE;
`ifdef CHECKSUM_EN
      S_CHECK: if (w_word_accept) w_next_state = w_sum_match ? S_READY : S_IDLE;
`endif
      S_READY: if (w_start) w_next_state = S_LOAD;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_word_count <= 10'd0;
      r_eff_len    <= 10'd0;
      r_byte_cnt   <= 2'd0;
      r_word_buf   <= 24'd0;
    end else if (w_start) begin
      r_word_count <= 10'd0;
      r_eff_len    <= w_eff_len;
      r_byte_cnt   <= 2'd0;
    end else if (w_accept) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      if (r_byte_cnt != 2'd3)
        r_word_buf[{r_byte_cnt, 3'b000} +: 8] <= bus.byte_data;
      if (w_word_accept && (r_state == S_LOAD))
        r_word_count <= r_word_count + 10'd1;
    end
  end

  // Storage is deliberately not reset; word_count masks stale contents.
  always_ff @(posedge wb_clk_i) begin
    if (w_word_accept && (r_state == S_LOAD))
      r_mem[r_word_count[8:0]] <= w_word;
  end

  assign bus.byte_ready   = w_byte_ready;
  assign bus.insMemDataIn = ({1'b0, bus.insMemAddr} < r_word_count) ? r_mem[bus.insMemAddr] : c_NOP;
  assign bus.insMemEn     = w_ready;
  assign bus.pc_control   = w_ready && bus.run_en;
  assign bus.word_count   = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_imem_loader
// Brief  : Randomized self-checking bench for imem_loader against a word-level
//          memory model; honours `define CHECKSUM_EN like the design.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst;
  imem_loader_if bus ();

  imem_loader dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] ref_mem [512];
  int          ref_count = 0;
  logic [7:0]  q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    if (gap) begin
      bus.byte_valid = 1'b0;
      tick();
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && t < 50) begin
      tick();
      t++;
    end
    if (!bus.byte_ready) begin
      n_checks++;
      $display("FAIL byte_accept_timeout: byte_ready=0 after %0d cycles, required 1", t);
    end else begin
      tick();
    end
    bus.byte_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: gap before every byte, 2: random gaps
  task automatic send_stream(input int mode);
    for (int i = 0; i < q.size(); i++)
      send_byte(q[i], (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1));
  endtask

  task automatic start_load(input int len);
    logic [31:0] l;
    l = len;
    bus.load_len   = l[9:0];
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic model_load(input int len);
    int eff;
    eff = (len > 512) ? 512 : len;
    for (int i = 0; i < eff; i++)
      ref_mem[i] = {q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]};
    ref_count = eff;
  endtask

  task automatic send_checksum();
`ifdef CHECKSUM_EN
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < ref_count; i++) s ^= ref_mem[i];
    for (int b = 0; b < 4; b++) send_byte(s[8*b +: 8], 1'b0);
`endif
  endtask

  task automatic fill_random(input int nbytes);
    q.delete();
    for (int i = 0; i < nbytes; i++) q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic test_fetch_window(input string tag, input int lo, input int hi);
    logic [31:0] exp;
    for (int a = lo; a <= hi && a < 512; a++) begin
      bus.insMemAddr = 9'(a);
      #1;
      exp = (a < ref_count) ? ref_mem[a] : 32'h13;
      n_checks++;
      if (bus.insMemDataIn !== exp)
        $display("FAIL %s fetch[%0d]: got %h required %h", tag, a, bus.insMemDataIn, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    ref_count = 0;
    n_checks++; if (bus.word_count !== 10'd0) $display("FAIL rst_word_count: got %0d required 0", bus.word_count); else n_pass++;
    n_checks++; if (bus.insMemEn !== 1'b0) $display("FAIL rst_insMemEn: got %b required 0", bus.insMemEn); else n_pass++;
    n_checks++; if (bus.pc_control !== 1'b0) $display("FAIL rst_pc_control: got %b required 0", bus.pc_control); else n_pass++;
    n_checks++; if (bus.byte_ready !== 1'b0) $display("FAIL rst_byte_ready: got %b required 0", bus.byte_ready); else n_pass++;
    n_checks++; if (bus.load_busy !== 1'b0) $display("FAIL rst_load_busy: got %b required 0", bus.load_busy); else n_pass++;
    n_checks++; if (bus.load_err !== 1'b0) $display("FAIL rst_load_err: got %b required 0", bus.load_err); else n_pass++;
    rst = 1'b0;
    test_fetch_window("rst", 0, 3);
  endtask

  task automatic test_basic();
    bus.run_en = 1'b1;
    start_load(2);
    q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    send_stream(0);
    model_load(2);
    send_checksum();
    n_checks++; if (bus.insMemEn !== 1'b1) $display("FAIL basic_insMemEn: got %b required 1", bus.insMemEn); else n_pass++;
    n_checks++; if (bus.pc_control !== 1'b1) $display("FAIL basic_pc_control: got %b required 1", bus.pc_control); else n_pass++;
    n_checks++; if (bus.word_count !== 10'd2) $display("FAIL basic_word_count: got %0d required 2", bus.word_count); else n_pass++;
    bus.insMemAddr = 9'd0; #1;
    n_checks++; if (bus.insMemDataIn !== 32'h00100513) $display("FAIL basic_word0: got %h required 00100513", bus.insMemDataIn); else n_pass++;
    bus.insMemAddr = 9'd1; #1;
    n_checks++; if (bus.insMemDataIn !== 32'h00200593) $display("FAIL basic_word1: got %h required 00200593", bus.insMemDataIn); else n_pass++;
    bus.insMemAddr = 9'd2; #1;
    n_checks++; if (bus.insMemDataIn !== 32'h00000013) $display("FAIL basic_word2_nop: got %h required 00000013", bus.insMemDataIn); else n_pass++;
  endtask

  task automatic test_stall();
    start_load(1);
    q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stream(1);
    model_load(1);
    send_checksum();
    bus.insMemAddr = 9'd0; #1;
    n_checks++; if (bus.insMemDataIn !== 32'hDEADBEEF) $display("FAIL stall_word0: got %h required deadbeef", bus.insMemDataIn); else n_pass++;
    n_checks++; if (bus.word_count !== 10'd1) $display("FAIL stall_word_count: got %0d required 1", bus.word_count); else n_pass++;
  endtask

  task automatic test_reset_midload();
    start_load(4);
    fill_random(6);
    send_stream(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ref_count = 0;
    n_checks++; if (bus.word_count !== 10'd0) $display("FAIL midrst_word_count: got %0d required 0", bus.word_count); else n_pass++;
    n_checks++; if (bus.insMemEn !== 1'b0) $display("FAIL midrst_insMemEn: got %b required 0", bus.insMemEn); else n_pass++;
    n_checks++; if (bus.load_busy !== 1'b0) $display("FAIL midrst_load_busy: got %b required 0", bus.load_busy); else n_pass++;
    test_fetch_window("midrst", 0, 2);
    test_fetch_window("midrst_rand", $urandom_range(3, 511), 511);
  endtask

  task automatic test_overflow();
    start_load(600);
    fill_random(2048);
    send_stream(0);
    model_load(600);
    send_checksum();
    n_checks++; if (bus.word_count !== 10'd512) $display("FAIL ovf_word_count: got %0d required 512", bus.word_count); else n_pass++;
    n_checks++; if (bus.byte_ready !== 1'b0) $display("FAIL ovf_byte_ready: got %b required 0", bus.byte_ready); else n_pass++;
    n_checks++; if (bus.insMemEn !== 1'b1) $display("FAIL ovf_insMemEn: got %b required 1", bus.insMemEn); else n_pass++;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hA5;
    repeat (3) tick();
    bus.byte_valid = 1'b0;
    n_checks++; if (bus.word_count !== 10'd512) $display("FAIL ovf_extra_bytes: got %0d required 512", bus.word_count); else n_pass++;
    test_fetch_window("ovf_lo", 0, 7);
    test_fetch_window("ovf_hi", 504, 511);
  endtask

  task automatic test_zero_len();
    start_load(0);
    q.delete();
    model_load(0);
`ifdef CHECKSUM_EN
    send_checksum();
`else
    tick();
`endif
    n_checks++; if (bus.insMemEn !== 1'b1) $display("FAIL zero_insMemEn: got %b required 1", bus.insMemEn); else n_pass++;
    n_checks++; if (bus.word_count !== 10'd0) $display("FAIL zero_word_count: got %0d required 0", bus.word_count); else n_pass++;
    n_checks++; if (bus.load_busy !== 1'b0) $display("FAIL zero_load_busy: got %b required 0", bus.load_busy); else n_pass++;
    test_fetch_window("zero", 0, 3);
  endtask

  task automatic test_reload();
    bus.run_en = 1'b1;
    start_load(3);
    fill_random(12);
    send_stream(0);
    model_load(3);
    send_checksum();
    n_checks++; if (bus.pc_control !== 1'b1) $display("FAIL reload_pre_pc: got %b required 1", bus.pc_control); else n_pass++;
    start_load(1);
    ref_count = 0;
    n_checks++; if (bus.pc_control !== 1'b0) $display("FAIL reload_pc_control: got %b required 0", bus.pc_control); else n_pass++;
    n_checks++; if (bus.insMemEn !== 1'b0) $display("FAIL reload_insMemEn: got %b required 0", bus.insMemEn); else n_pass++;
    n_checks++; if (bus.word_count !== 10'd0) $display("FAIL reload_word_count: got %0d required 0", bus.word_count); else n_pass++;
    n_checks++; if (bus.load_busy !== 1'b1) $display("FAIL reload_load_busy: got %b required 1", bus.load_busy); else n_pass++;
    test_fetch_window("reload_cleared", 0, 2);
    fill_random(4);
    send_byte(q[0], 1'b0);
    send_byte(q[1], 1'b0);
    start_load(5);
    n_checks++; if (bus.word_count !== 10'd0) $display("FAIL ignore_start_count: got %0d required 0", bus.word_count); else n_pass++;
    send_byte(q[2], 1'b0);
    send_byte(q[3], 1'b0);
    model_load(1);
    send_checksum();
    n_checks++; if (bus.word_count !== 10'd1) $display("FAIL ignore_start_final: got %0d required 1", bus.word_count); else n_pass++;
    n_checks++; if (bus.insMemEn !== 1'b1) $display("FAIL ignore_start_en: got %b required 1", bus.insMemEn); else n_pass++;
    test_fetch_window("reload", 0, 2);
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, 12);
      bus.run_en = 1'($urandom_range(0, 1));
      start_load(len);
      fill_random(4 * len);
      send_stream(2);
      model_load(len);
      send_checksum();
      n_checks++; if (bus.insMemEn !== 1'b1) $display("FAIL rand%0d_insMemEn: got %b required 1", it, bus.insMemEn); else n_pass++;
      n_checks++; if (bus.pc_control !== bus.run_en) $display("FAIL rand%0d_pc_control: got %b required %b", it, bus.pc_control, bus.run_en); else n_pass++;
      n_checks++; if (bus.word_count !== 10'(len)) $display("FAIL rand%0d_word_count: got %0d required %0d", it, bus.word_count, len); else n_pass++;
      test_fetch_window("rand", 0, len + 1);
    end
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    start_load(2);
    q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_stream(0);
    model_load(2);
    for (int b = 0; b < 4; b++) send_byte((b == 0) ? 8'h03 : 8'h00, 1'b0);
    n_checks++; if (bus.insMemEn !== 1'b1) $display("FAIL csum_ok_insMemEn: got %b required 1", bus.insMemEn); else n_pass++;
    n_checks++; if (bus.load_err !== 1'b0) $display("FAIL csum_ok_load_err: got %b required 0", bus.load_err); else n_pass++;
    start_load(2);
    send_stream(0);
    for (int b = 0; b < 4; b++) send_byte((b == 0) ? 8'h04 : 8'h00, 1'b0);
    n_checks++; if (bus.insMemEn !== 1'b0) $display("FAIL csum_bad_insMemEn: got %b required 0", bus.insMemEn); else n_pass++;
    n_checks++; if (bus.load_err !== 1'b1) $display("FAIL csum_bad_load_err: got %b required 1", bus.load_err); else n_pass++;
    n_checks++; if (bus.load_busy !== 1'b0) $display("FAIL csum_bad_load_busy: got %b required 0", bus.load_busy); else n_pass++;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.load_start = 1'b0;
    bus.load_len   = 10'd0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;
    bus.run_en     = 1'b0;
    bus.insMemAddr = 9'd0;
    test_reset();
    test_basic();
    test_stall();
    test_reset_midload();
    test_overflow();
    test_zero_len();
    test_reload();
    test_random();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
